// File: rtl/ldiv_pkg.sv
// Shared types and sizing helpers for the pipelined long divider.
package ldiv_pkg;

   typedef enum logic [1:0] {
      RES_NORMAL = 2'd0,
      RES_DIVZ   = 2'd1,
      RES_OVF    = 2'd2
   } res_kind_e;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Flattened width of the per-stage record:
   // kind(2) neg_q neg_r nraw(n) num(n) den(d) quo(n) rem(d+1) tag(t)
   function automatic int rec_width(input int n, input int d, input int t);
      return 5 + 3 * n + 2 * d + t;
   endfunction

endpackage

// File: rtl/ldiv_stage.sv
// One registered restoring-division step resolving up to K quotient bits, MSB first.
module ldiv_stage
   import ldiv_pkg::*;
#(
   parameter int N     = 16,
   parameter int D     = 16,
   parameter int T     = 4,
   parameter int K     = 1,
   parameter int STAGE = 1,
   localparam int REC_W = rec_width(N, D, T)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             adv_i,
   input  logic [REC_W-1:0] rec_i,
   output logic [REC_W-1:0] rec_o
);

   // The last stage only resolves whatever bits are left over.
   localparam int BITS = (STAGE * K > N) ? (N - (STAGE - 1) * K) : K;

   typedef struct packed {
      res_kind_e      kind;
      logic           neg_q;
      logic           neg_r;
      logic [N-1:0]   nraw;
      logic [N-1:0]   num;
      logic [D-1:0]   den;
      logic [N-1:0]   quo;
      logic [D:0]     rem;
      logic [T-1:0]   tag;
   } rec_t;

   rec_t       in_s, rec_d, rec_q;
   logic [D:0] r_v;

   assign in_s = rec_i;

   always_comb begin
      rec_d = in_s;
      r_v   = '0;
      for (int i = 0; i < BITS; i++) begin
         r_v       = {rec_d.rem[D-1:0], rec_d.num[N-1]};
         rec_d.num = {rec_d.num[N-2:0], 1'b0};
         if (r_v >= {1'b0, rec_d.den}) begin
            rec_d.rem = r_v - {1'b0, rec_d.den};
            rec_d.quo = {rec_d.quo[N-2:0], 1'b1};
         end else begin
            rec_d.rem = r_v;
            rec_d.quo = {rec_d.quo[N-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)      rec_q <= '0;
      else if (adv_i) rec_q <= rec_d;
   end

   assign rec_o = rec_q;

endmodule

// File: rtl/ldiv_pipe.sv
// Pipelined signed/unsigned long divider with tag passthrough, special-case flags
// and a global-stall ready/valid handshake.
module ldiv_pipe
   import ldiv_pkg::*;
#(
   parameter int NUMERATOR_WIDTH   = 16,
   parameter int DENOMINATOR_WIDTH = 16,
   parameter int BITS_PER_STAGE    = 1,
   parameter int TAG_WIDTH         = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid_in,
   output logic                         ready_in,
   input  logic                         signed_in,
   input  logic [NUMERATOR_WIDTH-1:0]   numerator_in,
   input  logic [DENOMINATOR_WIDTH-1:0] denominator_in,
   input  logic [TAG_WIDTH-1:0]         tag_in,
   output logic                         valid_out,
   input  logic                         ready_out,
   output logic [NUMERATOR_WIDTH-1:0]   quotient_out,
   output logic [NUMERATOR_WIDTH-1:0]   remainder_out,
   output logic [TAG_WIDTH-1:0]         tag_out,
   output logic                         div_zero_out,
   output logic                         overflow_out
);

   localparam int N      = NUMERATOR_WIDTH;
   localparam int D      = DENOMINATOR_WIDTH;
   localparam int T      = TAG_WIDTH;
   localparam int STAGES = ceil_div(N, BITS_PER_STAGE);
   localparam int REC_W  = rec_width(N, D, T);

   typedef struct packed {
      res_kind_e      kind;
      logic           neg_q;
      logic           neg_r;
      logic [N-1:0]   nraw;
      logic [N-1:0]   num;
      logic [D-1:0]   den;
      logic [N-1:0]   quo;
      logic [D:0]     rem;
      logic [T-1:0]   tag;
   } rec_t;

   logic              adv;
   logic [STAGES+1:0] vld_pipe_q;
   logic              neg_n, neg_d;
   rec_t              prep_d, prep_q, fin;
   logic [REC_W-1:0]  srec [0:STAGES];
   logic [N-1:0]      r_ext;
   logic [N-1:0]      quo_d, quo_q, rem_d, rem_q;
   logic [T-1:0]      tag_q;
   logic              dz_d, dz_q, ovf_d, ovf_q;
   logic              unused_fin;

   // Whole pipe moves together; only a held output result can stall it.
   assign adv      = !valid_out || ready_out;
   assign ready_in = adv;

   always_ff @(posedge clk) begin
      if (reset)    vld_pipe_q <= '0;
      else if (adv) vld_pipe_q <= {vld_pipe_q[STAGES:0], valid_in};
   end

   assign neg_n = signed_in & numerator_in[N-1];
   assign neg_d = signed_in & denominator_in[D-1];

   always_comb begin
      prep_d       = '0;
      prep_d.kind  = RES_NORMAL;
      if (denominator_in == '0)
         prep_d.kind = RES_DIVZ;
      else if (signed_in && numerator_in == {1'b1, {(N-1){1'b0}}} && &denominator_in)
         prep_d.kind = RES_OVF;
      prep_d.neg_q = neg_n ^ neg_d;
      prep_d.neg_r = neg_n;
      prep_d.nraw  = numerator_in;
      // Negating the most-negative value yields its correct unsigned magnitude.
      prep_d.num   = neg_n ? -numerator_in : numerator_in;
      prep_d.den   = neg_d ? -denominator_in : denominator_in;
      prep_d.tag   = tag_in;
   end

   always_ff @(posedge clk) begin
      if (reset)    prep_q <= '0;
      else if (adv) prep_q <= prep_d;
   end

   assign srec[0] = prep_q;

   for (genvar s = 1; s <= STAGES; s++) begin : g_stage
      ldiv_stage #(
         .N     (N),
         .D     (D),
         .T     (T),
         .K     (BITS_PER_STAGE),
         .STAGE (s)
      ) u_stage (
         .clk   (clk),
         .reset (reset),
         .adv_i (adv),
         .rec_i (srec[s-1]),
         .rec_o (srec[s])
      );
   end

   assign fin        = srec[STAGES];
   assign r_ext      = N'(fin.rem[D-1:0]);
   assign unused_fin = ^{fin.num, fin.den, fin.rem[D]};

   always_comb begin
      quo_d = fin.neg_q ? -fin.quo : fin.quo;
      rem_d = fin.neg_r ? -r_ext : r_ext;
      dz_d  = 1'b0;
      ovf_d = 1'b0;
      case (fin.kind)
         RES_DIVZ: begin
            quo_d = '1;
            rem_d = fin.nraw;
            dz_d  = 1'b1;
         end
         RES_OVF: begin
            quo_d = {1'b1, {(N-1){1'b0}}};
            rem_d = '0;
            ovf_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q <= '0;
         rem_q <= '0;
         tag_q <= '0;
         dz_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (adv) begin
         quo_q <= quo_d;
         rem_q <= rem_d;
         tag_q <= fin.tag;
         dz_q  <= dz_d;
         ovf_q <= ovf_d;
      end
   end

   assign valid_out     = vld_pipe_q[STAGES+1];
   assign quotient_out  = quo_q;
   assign remainder_out = rem_q;
   assign tag_out       = tag_q;
   assign div_zero_out  = dz_q;
   assign overflow_out  = ovf_q;

endmodule

// File: tb/tb_ldiv_pipe.sv
// Self-checking bench for ldiv_pipe: directed cases, randomized backpressure, alternate
// stage sizes, exhaustive 4-bit sweep and reset with operations in flight.
module tb_ldiv_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   errors = 0;
   int   checks = 0;

   // main instance N=8 D=8 K=2
   logic       v_in, s_in, r_out, ri, vo, dz, ov;
   logic [7:0] n_in, d_in, qo, ro;
   logic [3:0] t_in, to;

   ldiv_pipe #(.NUMERATOR_WIDTH(8), .DENOMINATOR_WIDTH(8), .BITS_PER_STAGE(2), .TAG_WIDTH(4)) u_dut (
      .clk(clk), .reset(rst), .valid_in(v_in), .ready_in(ri), .signed_in(s_in),
      .numerator_in(n_in), .denominator_in(d_in), .tag_in(t_in), .valid_out(vo),
      .ready_out(r_out), .quotient_out(qo), .remainder_out(ro), .tag_out(to),
      .div_zero_out(dz), .overflow_out(ov));

   // alternate 8-bit instances K=3 and K=8 sharing inputs
   logic       a_v, a_s, a_ro;
   logic [7:0] a_n, a_d;
   logic [3:0] a_t;
   logic       ri3, v3, z3, o3, ri8, v8, z8, o8;
   logic [7:0] q3, r3, q8, r8;
   logic [3:0] t3, t8;

   ldiv_pipe #(.NUMERATOR_WIDTH(8), .DENOMINATOR_WIDTH(8), .BITS_PER_STAGE(3), .TAG_WIDTH(4)) u_k3 (
      .clk(clk), .reset(rst), .valid_in(a_v), .ready_in(ri3), .signed_in(a_s),
      .numerator_in(a_n), .denominator_in(a_d), .tag_in(a_t), .valid_out(v3),
      .ready_out(a_ro), .quotient_out(q3), .remainder_out(r3), .tag_out(t3),
      .div_zero_out(z3), .overflow_out(o3));

   ldiv_pipe #(.NUMERATOR_WIDTH(8), .DENOMINATOR_WIDTH(8), .BITS_PER_STAGE(8), .TAG_WIDTH(4)) u_k8 (
      .clk(clk), .reset(rst), .valid_in(a_v), .ready_in(ri8), .signed_in(a_s),
      .numerator_in(a_n), .denominator_in(a_d), .tag_in(a_t), .valid_out(v8),
      .ready_out(a_ro), .quotient_out(q8), .remainder_out(r8), .tag_out(t8),
      .div_zero_out(z8), .overflow_out(o8));

   // 4-bit instances, K = 1..4
   logic       f_v, f_s, f_ro;
   logic [3:0] f_n, f_d, f_t;
   logic       v4 [1:4], rdy4 [1:4], dz4 [1:4], ov4 [1:4];
   logic [3:0] q4 [1:4], r4 [1:4], tg4 [1:4];

   for (genvar k = 1; k <= 4; k++) begin : g_n4
      ldiv_pipe #(.NUMERATOR_WIDTH(4), .DENOMINATOR_WIDTH(4), .BITS_PER_STAGE(k), .TAG_WIDTH(4)) u (
         .clk(clk), .reset(rst), .valid_in(f_v), .ready_in(rdy4[k]), .signed_in(f_s),
         .numerator_in(f_n), .denominator_in(f_d), .tag_in(f_t), .valid_out(v4[k]),
         .ready_out(f_ro), .quotient_out(q4[k]), .remainder_out(r4[k]), .tag_out(tg4[k]),
         .div_zero_out(dz4[k]), .overflow_out(ov4[k]));
   end

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic [3:0] t;
      logic       dz;
      logic       ov;
   } exp_t;

   // Reference: plain integer division with the special cases layered on top.
   function automatic void ref_div(input int w, input bit sgn, input int n, input int d,
                                   output logic [7:0] q, output logic [7:0] r,
                                   output logic edz, output logic eov);
      int mask = (1 << w) - 1;
      int half = 1 << (w - 1);
      int ns, ds;
      edz = 1'b0;
      eov = 1'b0;
      if (d == 0) begin
         q   = 8'(mask);
         r   = 8'(n);
         edz = 1'b1;
      end else if (sgn) begin
         ns = (n >= half) ? n - (1 << w) : n;
         ds = (d >= half) ? d - (1 << w) : d;
         if (ns == -half && ds == -1) begin
            q   = 8'(half);
            r   = 8'd0;
            eov = 1'b1;
         end else begin
            q = 8'((ns / ds) & mask);
            r = 8'((ns % ds) & mask);
         end
      end else begin
         q = 8'(n / d);
         r = 8'(n % d);
      end
   endfunction

   // Drive one op on the main instance and wait for its result (helper, no checking).
   task automatic run_main(input bit sg, input logic [7:0] n, input logic [7:0] d,
                           input logic [3:0] tg, output int lat);
      @(posedge clk); #1;
      v_in = 1'b1; s_in = sg; n_in = n; d_in = d; t_in = tg; r_out = 1'b1;
      @(posedge clk); #1;
      v_in = 1'b0;
      lat  = 1;
      while (lat < 30) begin
         @(negedge clk);
         if (vo) break;
         @(posedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({vo, qo, ro, to, dz, ov, ri} !== {1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_main got v=%0b q=%h r=%h t=%h dz=%0b ov=%0b rdy=%0b want v=0 q=00 r=00 t=0 dz=0 ov=0 rdy=1",
                  vo, qo, ro, to, dz, ov, ri);
      end
      checks++;
      if ({v3, v8, v4[1], v4[2], v4[3], v4[4]} !== 6'b0) begin
         errors++;
         $display("FAIL reset_alt valid got %b%b%b%b%b%b want 000000",
                  v3, v8, v4[1], v4[2], v4[3], v4[4]);
      end
   endtask

   task automatic test_directed();
      bit         sg_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [7:0] n_t  [7] = '{8'd200, 8'hF9, 8'h07, 8'h80, 8'h09, 8'h09, 8'h80};
      logic [7:0] d_t  [7] = '{8'd7, 8'h02, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'hFF};
      logic [7:0] q_t  [7] = '{8'd28, 8'hFD, 8'hFD, 8'h80, 8'hFF, 8'hFF, 8'h00};
      logic [7:0] r_t  [7] = '{8'd4, 8'hFF, 8'h01, 8'h00, 8'h09, 8'h09, 8'h80};
      bit         z_t  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      bit         o_t  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 7; i++) begin
         run_main(sg_t[i], n_t[i], d_t[i], 4'(i + 3), lat);
         checks++;
         if (lat != 6) begin
            errors++;
            $display("FAIL directed_latency[%0d] got %0d want 6", i, lat);
         end
         checks++;
         if ({qo, ro, to, dz, ov} !== {q_t[i], r_t[i], 4'(i + 3), z_t[i], o_t[i]}) begin
            errors++;
            $display("FAIL directed[%0d] got q=%h r=%h t=%h dz=%0b ov=%0b want q=%h r=%h t=%h dz=%0b ov=%0b",
                     i, qo, ro, to, dz, ov, q_t[i], r_t[i], 4'(i + 3), z_t[i], o_t[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t        expq [$];
      exp_t        e;
      logic [7:0]  eq, er;
      logic        edz, eov;
      int          acc = 0, got = 0, cyc = 0;
      logic        prev_hold = 1'b0;
      logic [22:0] prev_out = '0;
      while ((acc < 16 || got < 16) && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
         r_out = ($urandom_range(0, 2) != 0);
         if (acc < 16 && $urandom_range(0, 3) != 0) begin
            v_in = 1'b1;
            s_in = 1'($urandom);
            n_in = 8'($urandom);
            d_in = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
               s_in = 1'b1; n_in = 8'h80; d_in = 8'hFF;
            end
            t_in = 4'(acc);
         end else begin
            v_in = 1'b0;
         end
         @(negedge clk);
         if (prev_hold) begin
            checks++;
            if ({vo, qo, ro, to, dz, ov} !== prev_out) begin
               errors++;
               $display("FAIL b2b_stall_stable got %h want %h", {vo, qo, ro, to, dz, ov}, prev_out);
            end
         end
         if (v_in && ri) begin
            ref_div(8, s_in, n_in, d_in, eq, er, edz, eov);
            expq.push_back('{q: eq, r: er, t: t_in, dz: edz, ov: eov});
            acc++;
         end
         if (vo && r_out) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_result got t=%h want none", to);
            end else begin
               e = expq.pop_front();
               got++;
               if ({qo, ro, to, dz, ov} !== e) begin
                  errors++;
                  $display("FAIL b2b_result got q=%h r=%h t=%h dz=%0b ov=%0b want q=%h r=%h t=%h dz=%0b ov=%0b",
                           qo, ro, to, dz, ov, e.q, e.r, e.t, e.dz, e.ov);
               end
            end
         end
         prev_hold = vo && !r_out;
         prev_out  = {vo, qo, ro, to, dz, ov};
      end
      @(posedge clk); #1;
      v_in  = 1'b0;
      r_out = 1'b1;
      checks++;
      if (acc != 16 || got != 16 || expq.size() != 0) begin
         errors++;
         $display("FAIL b2b_count got acc=%0d out=%0d left=%0d want 16 16 0", acc, got, expq.size());
      end
   endtask

   task automatic test_alt_k();
      logic [7:0] eq, er;
      logic       edz, eov;
      int         lat;
      bit         got3, got8;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         a_v = 1'b1;
         a_s = 1'($urandom);
         a_n = 8'($urandom);
         a_d = 8'($urandom);
         a_t = 4'(i);
         if (i == 0) a_d = 8'h00;
         if (i == 1) begin a_s = 1'b1; a_n = 8'h80; a_d = 8'hFF; end
         ref_div(8, a_s, a_n, a_d, eq, er, edz, eov);
         @(posedge clk); #1;
         a_v  = 1'b0;
         lat  = 1;
         got3 = 1'b0;
         got8 = 1'b0;
         while (lat < 20 && !(got3 && got8)) begin
            @(negedge clk);
            if (v3 && !got3) begin
               got3 = 1'b1;
               checks++;
               if (lat != 5 || {q3, r3, t3, z3, o3} !== {eq, er, a_t, edz, eov}) begin
                  errors++;
                  $display("FAIL k3[%0d] got lat=%0d q=%h r=%h t=%h dz=%0b ov=%0b want lat=5 q=%h r=%h t=%h dz=%0b ov=%0b",
                           i, lat, q3, r3, t3, z3, o3, eq, er, a_t, edz, eov);
               end
            end
            if (v8 && !got8) begin
               got8 = 1'b1;
               checks++;
               if (lat != 3 || {q8, r8, t8, z8, o8} !== {eq, er, a_t, edz, eov}) begin
                  errors++;
                  $display("FAIL k8[%0d] got lat=%0d q=%h r=%h t=%h dz=%0b ov=%0b want lat=3 q=%h r=%h t=%h dz=%0b ov=%0b",
                           i, lat, q8, r8, t8, z8, o8, eq, er, a_t, edz, eov);
               end
            end
            @(posedge clk);
            lat++;
         end
         checks++;
         if (!(got3 && got8)) begin
            errors++;
            $display("FAIL alt_timeout[%0d] got k3=%0b k8=%0b want 1 1", i, got3, got8);
         end
      end
   endtask

   task automatic test_sweep4();
      int         cnt [1:4] = '{0, 0, 0, 0};
      logic [7:0] eq, er;
      logic       edz, eov;
      int         idx;
      for (int cyc = 0; cyc < 540; cyc++) begin
         @(posedge clk); #1;
         if (cyc < 512) begin
            f_v = 1'b1;
            f_s = 1'(cyc >> 8);
            f_n = 4'(cyc >> 4);
            f_d = 4'(cyc);
            f_t = 4'(cyc >> 2);
         end else begin
            f_v = 1'b0;
         end
         @(negedge clk);
         for (int k = 1; k <= 4; k++) begin
            if (v4[k]) begin
               checks++;
               idx = cnt[k];
               if (idx >= 512) begin
                  errors++;
                  $display("FAIL sweep4_extra k=%0d got result %0d want none", k, idx);
               end else begin
                  ref_div(4, 1'(idx >> 8), (idx >> 4) & 15, idx & 15, eq, er, edz, eov);
                  if ({q4[k], r4[k], tg4[k], dz4[k], ov4[k]} !== {eq[3:0], er[3:0], 4'(idx >> 2), edz, eov}) begin
                     errors++;
                     $display("FAIL sweep4 k=%0d op=%0d got q=%h r=%h t=%h dz=%0b ov=%0b want q=%h r=%h t=%h dz=%0b ov=%0b",
                              k, idx, q4[k], r4[k], tg4[k], dz4[k], ov4[k], eq[3:0], er[3:0], 4'(idx >> 2), edz, eov);
                  end
               end
               cnt[k]++;
            end
         end
      end
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (cnt[k] != 512) begin
            errors++;
            $display("FAIL sweep4_count k=%0d got %0d want 512", k, cnt[k]);
         end
      end
   endtask

   task automatic test_reset_flight();
      r_out = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         v_in = 1'b1;
         s_in = 1'($urandom);
         n_in = 8'($urandom);
         d_in = 8'($urandom_range(1, 255));
         t_in = 4'(i);
      end
      @(posedge clk); #1;
      v_in = 1'b0;
      rst  = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         checks++;
         if (vo !== 1'b0) begin
            errors++;
            $display("FAIL reset_flight cycle %0d got valid_out=%0b want 0", c, vo);
         end
         @(posedge clk);
      end
      @(negedge clk);
      checks++;
      if (ri !== 1'b1) begin
         errors++;
         $display("FAIL reset_flight_ready got %0b want 1", ri);
      end
   endtask

   initial begin
      rst  = 1'b1;
      v_in = 1'b0; s_in = 1'b0; r_out = 1'b1; n_in = '0; d_in = '0; t_in = '0;
      a_v  = 1'b0; a_s = 1'b0; a_ro = 1'b1; a_n = '0; a_d = '0; a_t = '0;
      f_v  = 1'b0; f_s = 1'b0; f_ro = 1'b1; f_n = '0; f_d = '0; f_t = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_alt_k();
      test_sweep4();
      test_reset_flight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
